// File: rtl/mips_debug_pkg.sv
// Shared constants and types for the MicroBlaze-to-MIPS debug command engine.
package mips_debug_pkg;

  localparam int unsigned NB_CONTROL_FRAME = 32;
  localparam int unsigned NB_INSTR_ADDR    = 10;
  localparam int unsigned NB_DATA          = 32;
  localparam int unsigned NB_CODE          = 6;
  localparam int unsigned NB_ADDR_TYPE     = 10;
  localparam int unsigned NB_FIELD_DATA    = 16;
  localparam int unsigned NB_STATUS        = 16;

  typedef enum logic [NB_CODE-1:0] {
    CMD_START          = 6'b000001,
    CMD_RESET          = 6'b000010,
    CMD_REQ_DATA       = 6'b000011,
    CMD_LOAD_INSTR_LSB = 6'b000100,
    CMD_LOAD_INSTR_MSB = 6'b000101,
    CMD_MODE_GET       = 6'b001000,
    CMD_MODE_SET       = 6'b001001,
    CMD_STEP           = 6'b100000
  } cmd_e;

  // Debug source selectors carried in the addr_type field of REQ_DATA.
  localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_DATA       = 10'h001;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_INSTR      = 10'h002;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_PC             = 10'h003;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_REG            = 10'h004;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_IF_ID    = 10'h005;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_ID_EX    = 10'h006;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_EX_MEM   = 10'h007;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_WB   = 10'h008;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_LATCH_MEM_CTRL = 10'h009;

  localparam logic [NB_STATUS-1:0] STATUS_OK   = 16'h0000;
  localparam logic [NB_STATUS-1:0] STATUS_ERR  = 16'hFFFF;
  localparam logic [NB_STATUS-1:0] STATUS_HALT = 16'h0001;

  typedef struct packed {
    logic [NB_CODE-1:0]       code;
    logic [NB_ADDR_TYPE-1:0]  addr_type;
    logic [NB_FIELD_DATA-1:0] data;
  } frame_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_LSB,
    ST_LOAD_MSB,
    ST_RUN,
    ST_READ_WAIT,
    ST_READ_CAP,
    ST_ACK,
    ST_RESP
  } state_e;

  function automatic logic [NB_CONTROL_FRAME-1:0] make_ack(input logic [NB_CODE-1:0] code,
                                                           input logic [NB_STATUS-1:0] status);
    return {code, 10'b0, status};
  endfunction

endpackage

// File: rtl/mips_debug_if.sv
// Frame link between the MicroBlaze bridge (master) and the debug unit (slave).
interface mips_debug_if;
  import mips_debug_pkg::*;

  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze;
  logic                        i_frame_valid;
  logic                        o_busy;
  logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze;
  logic                        o_frame_valid;

  modport master (
    output i_frame_from_blaze, i_frame_valid,
    input  o_busy, o_frame_to_blaze, o_frame_valid
  );

  modport slave (
    input  i_frame_from_blaze, i_frame_valid,
    output o_busy, o_frame_to_blaze, o_frame_valid
  );
endinterface

// File: rtl/debug_frame_decoder.sv
// Combinational split of a command frame into its fields plus a known-code flag.
module debug_frame_decoder
  import mips_debug_pkg::*;
(
  input  logic [NB_CONTROL_FRAME-1:0] i_frame,
  output logic [NB_CODE-1:0]          o_code_c,
  output logic [NB_ADDR_TYPE-1:0]     o_addr_type_c,
  output logic [NB_FIELD_DATA-1:0]    o_data_c,
  output logic                        o_code_valid_c
);

  frame_t fields;

  assign fields        = frame_t'(i_frame);
  assign o_code_c      = fields.code;
  assign o_addr_type_c = fields.addr_type;
  assign o_data_c      = fields.data;

  always_comb begin
    o_code_valid_c = 1'b0;
    case (fields.code)
      CMD_START, CMD_RESET, CMD_REQ_DATA, CMD_LOAD_INSTR_LSB,
      CMD_LOAD_INSTR_MSB, CMD_MODE_GET, CMD_MODE_SET, CMD_STEP: o_code_valid_c = 1'b1;
      default:                                                  o_code_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_debug_unit.sv
// Debug command engine: decodes MicroBlaze frames, drives the MIPS core and
// instruction memory, and returns one response frame per accepted command.
module mips_debug_unit
  import mips_debug_pkg::*;
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  mips_debug_if.slave              link,
  output logic                     o_mips_enable,
  output logic                     o_mips_reset,
  input  logic                     i_mips_halt,
  output logic                     o_imem_wr_en,
  output logic [NB_INSTR_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0]       o_imem_data,
  output logic [NB_ADDR_TYPE-1:0]  o_dbg_sel,
  output logic [NB_FIELD_DATA-1:0] o_dbg_addr,
  input  logic [NB_DATA-1:0]       i_dbg_data
);

  logic [NB_CODE-1:0]       dec_code;
  logic [NB_ADDR_TYPE-1:0]  dec_addr_type;
  logic [NB_FIELD_DATA-1:0] dec_data;
  logic                     dec_code_valid;

  debug_frame_decoder u_decoder (
    .i_frame        (link.i_frame_from_blaze),
    .o_code_c       (dec_code),
    .o_addr_type_c  (dec_addr_type),
    .o_data_c       (dec_data),
    .o_code_valid_c (dec_code_valid)
  );

  state_e                      state_q,     state_d;
  logic [NB_CODE-1:0]          code_q,      code_d;
  logic [NB_FIELD_DATA-1:0]    data_q,      data_d;
  logic [NB_STATUS-1:0]        status_q,    status_d;
  logic [NB_FIELD_DATA-1:0]    lsb_q,       lsb_d;
  logic [NB_INSTR_ADDR-1:0]    counter_q,   counter_d;
  logic                        mode_q,      mode_d;
  logic                        armed_q,     armed_d;
  logic                        halted_q,    halted_d;
  logic                        busy_q,      busy_d;
  logic [NB_CONTROL_FRAME-1:0] resp_q,      resp_d;
  logic                        resp_vld_q,  resp_vld_d;
  logic                        enable_q,    enable_d;
  logic                        mips_rst_q,  mips_rst_d;
  logic                        wr_en_q,     wr_en_d;
  logic [NB_INSTR_ADDR-1:0]    imem_addr_q, imem_addr_d;
  logic [NB_DATA-1:0]          imem_data_q, imem_data_d;
  logic [NB_ADDR_TYPE-1:0]     dbg_sel_q,   dbg_sel_d;
  logic [NB_FIELD_DATA-1:0]    dbg_addr_q,  dbg_addr_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    data_d      = data_q;
    status_d    = status_q;
    lsb_d       = lsb_q;
    counter_d   = counter_q;
    mode_d      = mode_q;
    armed_d     = armed_q;
    halted_d    = halted_q | i_mips_halt;
    resp_d      = resp_q;
    resp_vld_d  = 1'b0;
    enable_d    = 1'b0;
    mips_rst_d  = 1'b0;
    wr_en_d     = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    dbg_sel_d   = dbg_sel_q;
    dbg_addr_d  = dbg_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (link.i_frame_valid) begin
          code_d   = dec_code;
          data_d   = dec_data;
          status_d = STATUS_OK;
          state_d  = ST_ACK;
          if (!dec_code_valid) begin
            status_d = STATUS_ERR;
          end else begin
            case (dec_code)
              CMD_LOAD_INSTR_LSB: state_d = ST_LOAD_LSB;
              CMD_LOAD_INSTR_MSB: state_d = ST_LOAD_MSB;
              CMD_START: begin
                // Step mode only arms; continuous mode runs until halt.
                if (mode_q) begin
                  armed_d = 1'b1;
                end else begin
                  enable_d = ~i_mips_halt;
                  state_d  = ST_RUN;
                end
              end
              CMD_STEP: begin
                if (armed_q && !halted_q) enable_d = 1'b1;
                else                      status_d = STATUS_ERR;
              end
              CMD_REQ_DATA: begin
                dbg_sel_d  = dec_addr_type;
                dbg_addr_d = dec_data;
                state_d    = ST_READ_WAIT;
              end
              CMD_RESET: begin
                mips_rst_d = 1'b1;
                counter_d  = '0;
                armed_d    = 1'b0;
                halted_d   = 1'b0;
              end
              CMD_MODE_SET: begin
                mode_d  = dec_data[0];
                armed_d = 1'b0;
              end
              CMD_MODE_GET: status_d = {15'b0, mode_q};
              default:      status_d = STATUS_ERR;
            endcase
          end
        end
      end

      ST_LOAD_LSB: begin
        lsb_d      = data_q;
        resp_d     = make_ack(code_q, status_q);
        resp_vld_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_LOAD_MSB: begin
        wr_en_d     = 1'b1;
        imem_addr_d = counter_q;
        imem_data_d = {data_q, lsb_q};
        counter_d   = counter_q + NB_INSTR_ADDR'(1);
        resp_d      = make_ack(code_q, status_q);
        resp_vld_d  = 1'b1;
        state_d     = ST_RESP;
      end

      ST_RUN: begin
        if (i_mips_halt) begin
          resp_d     = make_ack(CMD_START, STATUS_HALT);
          resp_vld_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          enable_d = 1'b1;
        end
      end

      // Selector is registered this cycle; source data follows one cycle later.
      ST_READ_WAIT: state_d = ST_READ_CAP;

      ST_READ_CAP: begin
        resp_d     = i_dbg_data;
        resp_vld_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_ACK: begin
        resp_d     = make_ack(code_q, status_q);
        resp_vld_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      data_q      <= '0;
      status_q    <= '0;
      lsb_q       <= '0;
      counter_q   <= '0;
      mode_q      <= 1'b0;
      armed_q     <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
      enable_q    <= 1'b0;
      mips_rst_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      dbg_sel_q   <= '0;
      dbg_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      data_q      <= data_d;
      status_q    <= status_d;
      lsb_q       <= lsb_d;
      counter_q   <= counter_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
      resp_q      <= resp_d;
      resp_vld_q  <= resp_vld_d;
      enable_q    <= enable_d;
      mips_rst_q  <= mips_rst_d;
      wr_en_q     <= wr_en_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dbg_sel_q   <= dbg_sel_d;
      dbg_addr_q  <= dbg_addr_d;
    end
  end

  assign link.o_busy           = busy_q;
  assign link.o_frame_to_blaze = resp_q;
  assign link.o_frame_valid    = resp_vld_q;
  assign o_mips_enable         = enable_q;
  assign o_mips_reset          = mips_rst_q;
  assign o_imem_wr_en          = wr_en_q;
  assign o_imem_addr           = imem_addr_q;
  assign o_imem_data           = imem_data_q;
  assign o_dbg_sel             = dbg_sel_q;
  assign o_dbg_addr            = dbg_addr_q;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench for mips_debug_unit: responses and imem writes are queued
// when commands are issued and checked by monitors as the DUT produces them.
module tb_mips_debug_unit;
  import mips_debug_pkg::*;

  typedef struct {
    logic [31:0] resp;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic [31:0] dbg_data;
  logic        mips_en, mips_rst, wr_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [9:0]  dbg_sel;
  logic [15:0] dbg_addr;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en_total = 0;
  int   rst_total = 0;
  logic [9:0] exp_ctr = '0;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  mips_debug_if link();

  mips_debug_unit dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .link          (link),
    .o_mips_enable (mips_en),
    .o_mips_reset  (mips_rst),
    .i_mips_halt   (halt),
    .o_imem_wr_en  (wr_en),
    .o_imem_addr   (imem_addr),
    .o_imem_data   (imem_data),
    .o_dbg_sel     (dbg_sel),
    .o_dbg_addr    (dbg_addr),
    .i_dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ack(input logic [5:0] c, input logic [15:0] s);
    return {c, 10'b0, s};
  endfunction

  function automatic logic [31:0] dbg_model(input logic [9:0] s, input logic [15:0] a);
    if (s == 10'h004 && a == 16'd5) return 32'hDEADBEEF;
    return {6'h2A, s, a};
  endfunction

  // Debug sources answer one cycle after the selector is presented.
  always @(posedge clk) dbg_data <= dbg_model(dbg_sel, dbg_addr);

  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (mips_en)  en_total++;
    if (mips_rst) rst_total++;
    if (link.o_frame_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got %h at cycle %0d", link.o_frame_to_blaze, cyc);
      end else begin
        e = exp_q.pop_front();
        if (link.o_frame_to_blaze !== e.resp || cyc != e.cyc) begin
          bad++;
          $display("FAIL resp: got %h at cycle %0d, want %h at cycle %0d",
                   link.o_frame_to_blaze, cyc, e.resp, e.cyc);
        end
      end
    end
    if (wr_en) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL imem_unexpected: addr=%0d data=%h", imem_addr, imem_data);
      end else begin
        w = wr_q.pop_front();
        if (imem_addr !== w.addr || imem_data !== w.data) begin
          bad++;
          $display("FAIL imem_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   imem_addr, imem_data, w.addr, w.data);
        end
      end
    end
  end

  task automatic send(input logic [5:0] code, input logic [9:0] at, input logic [15:0] d,
                      input bit want_resp, input logic [31:0] exp_resp, input int lat);
    @(negedge clk);
    link.i_frame_from_blaze = {code, at, d};
    link.i_frame_valid      = 1'b1;
    if (want_resp) exp_q.push_back('{resp: exp_resp, cyc: cyc + lat});
    @(negedge clk);
    link.i_frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || link.o_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || link.o_busy) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d busy=%b, want pending=0 busy=0", name, exp_q.size(), link.o_busy);
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic cmd(input logic [5:0] code, input logic [9:0] at, input logic [15:0] d,
                     input logic [31:0] exp_resp, input int lat, input string name);
    send(code, at, d, 1'b1, exp_resp, lat);
    wait_idle(name);
  endtask

  task automatic load_pair(input logic [15:0] msb, input logic [15:0] lsb);
    cmd(CMD_LOAD_INSTR_LSB, 10'h0, lsb, ack(CMD_LOAD_INSTR_LSB, 16'h0), 2, "load_lsb");
    wr_q.push_back('{addr: exp_ctr, data: {msb, lsb}});
    cmd(CMD_LOAD_INSTR_MSB, 10'h0, msb, ack(CMD_LOAD_INSTR_MSB, 16'h0), 2, "load_msb");
    exp_ctr = exp_ctr + 10'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0;
    link.i_frame_valid = 1'b0; link.i_frame_from_blaze = '0;
    repeat (3) @(negedge clk);
    total += 6;
    if (link.o_busy !== 1'b0)          begin bad++; $display("FAIL rst_busy: got %b want 0", link.o_busy); end
    if (link.o_frame_valid !== 1'b0)   begin bad++; $display("FAIL rst_fvalid: got %b want 0", link.o_frame_valid); end
    if (link.o_frame_to_blaze !== '0)  begin bad++; $display("FAIL rst_frame: got %h want 0", link.o_frame_to_blaze); end
    if ({mips_en, mips_rst, wr_en} !== 3'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 000", {mips_en, mips_rst, wr_en}); end
    if ({imem_addr, imem_data} !== '0) begin bad++; $display("FAIL rst_imem: got %h/%h want 0/0", imem_addr, imem_data); end
    if ({dbg_sel, dbg_addr} !== '0)    begin bad++; $display("FAIL rst_dbg: got %h/%h want 0/0", dbg_sel, dbg_addr); end
    rst = 1'b0;
  endtask

  task automatic test_mode_unknown();
    cmd(CMD_MODE_GET, 10'h0, 16'h0, 32'h2000_0000, 2, "mode_get0");
    cmd(6'h3F, 10'h155, 16'hAAAA, 32'hFC00_FFFF, 2, "unknown");
    cmd(CMD_MODE_GET, 10'h0, 16'h0, 32'h2000_0000, 2, "mode_get_after_unknown");
  endtask

  task automatic test_load();
    exp_ctr = '0;
    load_pair(16'h1234, 16'h5678);
    load_pair(16'hCAFE, 16'hBABE);
    total++;
    if (wr_q.size() != 0) begin bad++; $display("FAIL load_writes: pending=%0d want 0", wr_q.size()); end
  endtask

  task automatic test_read();
    cmd(CMD_REQ_DATA, REQ_REG, 16'd5, 32'hDEADBEEF, 3, "read_reg");
    total++;
    if (dbg_sel !== 10'h004 || dbg_addr !== 16'd5) begin
      bad++; $display("FAIL read_sel: got %h/%h want 004/0005", dbg_sel, dbg_addr);
    end
    cmd(CMD_MODE_GET, 10'h0, 16'h0, 32'h2000_0000, 2, "mode_get_hold");
    total++;
    if (dbg_sel !== 10'h004 || dbg_addr !== 16'd5) begin
      bad++; $display("FAIL read_hold: got %h/%h want 004/0005", dbg_sel, dbg_addr);
    end
  endtask

  task automatic test_back_to_back();
    send(CMD_REQ_DATA, REQ_LATCH_EX_MEM, 16'h0123, 1'b1, {6'h2A, 10'h007, 16'h0123}, 3);
    wait_idle("b2b_read0");
    send(CMD_REQ_DATA, REQ_MEM_DATA, 16'hFFFF, 1'b1, {6'h2A, 10'h001, 16'hFFFF}, 3);
    wait_idle("b2b_read1");
  endtask

  task automatic test_run();
    int ens = 0;
    @(negedge clk);
    link.i_frame_from_blaze = {CMD_START, 10'h0, 16'h0};
    link.i_frame_valid = 1'b1;
    exp_q.push_back('{resp: 32'h0400_0001, cyc: cyc + 21});
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      link.i_frame_valid = 1'b0;
      if (mips_en) ens++;
      if (ens == 20) halt = 1'b1;
      if (i == 5) begin
        total++;
        if (link.o_busy !== 1'b1) begin bad++; $display("FAIL run_busy: got %b want 1", link.o_busy); end
        link.i_frame_from_blaze = {CMD_MODE_GET, 10'h0, 16'h0};
        link.i_frame_valid = 1'b1;
      end
    end
    halt = 1'b0;
    total++;
    if (ens != 20) begin bad++; $display("FAIL run_enable_cycles: got %0d want 20", ens); end
    wait_idle("run");
  endtask

  task automatic test_run_halted_start();
    int e0;
    halt = 1'b1;
    e0 = en_total;
    cmd(CMD_START, 10'h0, 16'h0, 32'h0400_0001, 2, "run_halted");
    halt = 1'b0;
    total++;
    if (en_total != e0) begin bad++; $display("FAIL run_halted_enable: got %0d want 0", en_total - e0); end
  endtask

  task automatic test_reset_cmd();
    int r0 = rst_total;
    cmd(CMD_RESET, 10'h0, 16'h0, 32'h0800_0000, 2, "reset_cmd");
    total++;
    if (rst_total - r0 != 1) begin bad++; $display("FAIL reset_pulse: got %0d cycles want 1", rst_total - r0); end
    exp_ctr = '0;
    load_pair(16'h0BAD, 16'hF00D);
  endtask

  task automatic test_step();
    int e0;
    cmd(CMD_MODE_SET, 10'h0, 16'h1, 32'h2400_0000, 2, "mode_set1");
    cmd(CMD_MODE_GET, 10'h0, 16'h0, 32'h2000_0001, 2, "mode_get1");
    e0 = en_total;
    cmd(CMD_STEP, 10'h0, 16'h0, 32'h8000_FFFF, 2, "step_unarmed");
    cmd(CMD_START, 10'h0, 16'h0, 32'h0400_0000, 2, "start_step_mode");
    total++;
    if (en_total != e0) begin bad++; $display("FAIL step_unarmed_enable: got %0d want 0", en_total - e0); end
    for (int k = 0; k < 3; k++) begin
      e0 = en_total;
      cmd(CMD_STEP, 10'h0, 16'h0, 32'h8000_0000, 2, "step");
      total++;
      if (en_total - e0 != 1) begin bad++; $display("FAIL step_enable_%0d: got %0d want 1", k, en_total - e0); end
    end
    @(negedge clk) halt = 1'b1;
    @(negedge clk) halt = 1'b0;
    e0 = en_total;
    cmd(CMD_STEP, 10'h0, 16'h0, 32'h8000_FFFF, 2, "step_halted");
    total++;
    if (en_total != e0) begin bad++; $display("FAIL step_halted_enable: got %0d want 0", en_total - e0); end
  endtask

  task automatic test_counter_wrap();
    cmd(CMD_RESET, 10'h0, 16'h0, 32'h0800_0000, 2, "reset_before_wrap");
    exp_ctr = '0;
    for (int i = 0; i < 1025; i++) load_pair(16'(i ^ 16'h9C00), 16'(i * 7));
    total += 2;
    if (wr_q.size() != 0) begin bad++; $display("FAIL wrap_writes: pending=%0d want 0", wr_q.size()); end
    if (imem_addr !== 10'd0) begin bad++; $display("FAIL wrap_last_addr: got %0d want 0", imem_addr); end
  endtask

  task automatic test_reset_during_run();
    cmd(CMD_MODE_SET, 10'h0, 16'h0, 32'h2400_0000, 2, "mode_set0");
    cmd(CMD_RESET, 10'h0, 16'h0, 32'h0800_0000, 2, "reset_clear_halt");
    send(CMD_START, 10'h0, 16'h0, 1'b0, 32'h0, 0);
    repeat (4) @(negedge clk);
    total++;
    if (mips_en !== 1'b1) begin bad++; $display("FAIL rrun_enable: got %b want 1", mips_en); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({mips_en, link.o_busy, link.o_frame_valid} !== 3'b000) begin
      bad++; $display("FAIL rrun_abort: en/busy/valid got %b want 000", {mips_en, link.o_busy, link.o_frame_valid});
    end
    @(negedge clk) rst = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (en_total < 0 || mips_en !== 1'b0) begin bad++; $display("FAIL rrun_idle_enable: got %b want 0", mips_en); end
    cmd(CMD_MODE_GET, 10'h0, 16'h0, 32'h2000_0000, 2, "mode_after_reset");
    exp_ctr = '0;
    load_pair(16'h7777, 16'h1111);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode_unknown();
    test_load();
    test_read();
    test_back_to_back();
    test_run();
    test_run_halted_start();
    test_reset_cmd();
    test_step();
    test_counter_wrap();
    test_reset_during_run();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
